// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: arbitrates instruction fetch and data requests onto
// a single handshaked memory port, with LDI/STI pointer indirection.
// Optional feature: define LC3_MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without mem_complete and raise the sticky err flag.
module lc3_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  // instruction fetch side
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_done,
  // data side
  input  logic        d_req,
  input  logic [1:0]  d_op,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  // memory port
  output logic        mem_en,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_complete,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_IND,
    S_RESP
  } state_t;

  state_t      state_q,    state_d;
  logic        mem_en_q,   mem_en_d;
  logic        mem_rd_q,   mem_rd_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q,  mem_din_d;
  logic [15:0] if_data_q,  if_data_d;
  logic [15:0] d_rdata_q,  d_rdata_d;
  logic        if_done_q,  if_done_d;
  logic        d_done_q,   d_done_d;
  // Captured request context: store-vs-load, store data, which requester.
  logic        wr_q,       wr_d;
  logic [15:0] wdata_q,    wdata_d;
  logic        data_side_q, data_side_d;
  // Set during the one strobe-low cycle between the pointer read and the
  // final access of LDI/STI.
  logic        ptr_phase_q, ptr_phase_d;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q,     err_d;
`endif

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    data_side_d = data_side_q;
    ptr_phase_d = ptr_phase_q;
`ifdef LC3_MEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // The requester still holds req during its done cycle; wait one more
        // cycle so a finished request is not accepted twice.
        if (!(if_done_q || d_done_q)) begin
          if (d_req) begin
            data_side_d = 1'b1;
            wr_d        = d_op[0];
            wdata_d     = d_wdata;
            ptr_phase_d = 1'b0;
            mem_en_d    = 1'b1;
            mem_addr_d  = d_addr;
            if (d_op[1]) begin
              // Indirect: the first access always reads the pointer.
              state_d  = S_IND;
              mem_rd_d = 1'b1;
            end else begin
              state_d   = S_DATA;
              mem_rd_d  = ~d_op[0];
              mem_din_d = d_wdata;
            end
          end else if (if_req) begin
            data_side_d = 1'b0;
            state_d     = S_FETCH;
            mem_en_d    = 1'b1;
            mem_rd_d    = 1'b1;
            mem_addr_d  = if_addr;
          end
        end
      end

      S_FETCH: begin
        if (mem_en_q && mem_complete) begin
          if_data_d = mem_dout;
          mem_en_d  = 1'b0;
          state_d   = S_RESP;
        end
      end

      S_DATA: begin
        if (mem_en_q && mem_complete) begin
          if (!wr_q) d_rdata_d = mem_dout;
          mem_en_d = 1'b0;
          state_d  = S_RESP;
        end
      end

      S_IND: begin
        if (ptr_phase_q) begin
          // Strobe was low for exactly this cycle; start the final access.
          ptr_phase_d = 1'b0;
          state_d     = S_DATA;
          mem_en_d    = 1'b1;
          mem_rd_d    = ~wr_q;
          mem_din_d   = wdata_q;
        end else if (mem_en_q && mem_complete) begin
          mem_addr_d  = mem_dout;
          mem_en_d    = 1'b0;
          ptr_phase_d = 1'b1;
        end
      end

      S_RESP: begin
        if (data_side_q) d_done_d  = 1'b1;
        else             if_done_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef LC3_MEM_TIMEOUT_EN
    // The counter only runs while the strobe is high and unanswered; any
    // strobe-low cycle (idle, indirection gap) clears it for the next access.
    if (!mem_en_q) begin
      tmo_cnt_d = '0;
    end else if (!mem_complete &&
                 (state_q == S_FETCH || state_q == S_DATA || state_q == S_IND)) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_cnt_d   = '0;
        mem_en_d    = 1'b0;
        err_d       = 1'b1;
        ptr_phase_d = 1'b0;
        state_d     = S_RESP;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_rd_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      data_side_q <= 1'b0;
      ptr_phase_q <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      data_side_q <= data_side_d;
      ptr_phase_q <= ptr_phase_d;
`ifdef LC3_MEM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign if_data  = if_data_q;
  assign if_done  = if_done_q;
  assign d_rdata  = d_rdata_q;
  assign d_done   = d_done_q;
`ifdef LC3_MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed testbench for lc3_mem_ctrl with a behavioural memory responder.
// Define LC3_MEM_TIMEOUT_EN to also exercise the timeout abort.
module tb_lc3_mem_ctrl;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 64;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_done;
  logic        d_req;
  logic [1:0]  d_op;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_complete;
  logic        err;

  lc3_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_data      (if_data),
    .if_done      (if_done),
    .d_req        (d_req),
    .d_op         (d_op),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .mem_en       (mem_en),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_complete (mem_complete),
    .err          (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model and responder controls.
  logic [15:0] mem [0:65535];
  int          wait_cycles = 0;
  bit          stall       = 1'b0;
  bit          spurious    = 1'b0;
  logic        log_rd   [$];
  logic [15:0] log_addr [$];
  logic [15:0] log_data [$];

  // Responder: answers an open strobe after wait_cycles low-complete cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_complete = 1'b0;
    mem_dout = 16'h0;
    forever begin
      @(negedge clock);
      if (reset_n && mem_en && !stall) begin
        if (wcnt >= wait_cycles) begin
          mem_complete = 1'b1;
          log_rd.push_back(mem_rd);
          log_addr.push_back(mem_addr);
          if (mem_rd) begin
            mem_dout = mem[mem_addr];
            log_data.push_back(mem[mem_addr]);
          end else begin
            mem[mem_addr] = mem_din;
            log_data.push_back(mem_din);
          end
          wcnt = 0;
        end else begin
          mem_complete = 1'b0;
          wcnt++;
        end
      end else begin
        mem_complete = spurious;
        mem_dout = 16'hDEAD;
        wcnt = 0;
      end
    end
  end

  // Monitor: strobe edges and done pulses, counted on negedges.
  int   cyc = 0;
  int   rise_q [$];
  int   fall_q [$];
  int   if_done_cnt = 0;
  int   d_done_cnt  = 0;
  logic en_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (mem_en === 1'b1 && en_prev !== 1'b1) rise_q.push_back(cyc);
      if (mem_en !== 1'b1 && en_prev === 1'b1) fall_q.push_back(cyc);
      en_prev = mem_en;
      if (if_done === 1'b1) if_done_cnt++;
      if (d_done === 1'b1)  d_done_cnt++;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    log_rd.delete();
    log_addr.delete();
    log_data.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  // Fetch transaction; lat = edges from the accepting edge to done.
  task automatic run_fetch(input logic [15:0] addr, output int lat);
    int steps;
    steps = 0;
    if_addr = addr;
    if_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      steps++;
      if (steps == 1) if_addr = ~addr;  // must be ignored after capture
      if (if_done === 1'b1) break;
    end
    lat = steps - 1;
    if (if_done !== 1'b1) check("fetch_done_seen", {31'b0, if_done}, 32'h1);
    if_req = 1'b0;
    step();
    check("fetch_done_one_cycle", {31'b0, if_done}, 32'h0);
  endtask

  // Data transaction; inputs are scrambled once the request is captured.
  task automatic run_data(input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat);
    int steps;
    steps = 0;
    d_op    = op;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      steps++;
      if (steps == 1) begin
        d_op    = ~op;
        d_addr  = ~addr;
        d_wdata = ~wdata;
      end
      if (d_done === 1'b1) break;
    end
    lat = steps - 1;
    if (d_done !== 1'b1) check("data_done_seen", {31'b0, d_done}, 32'h1);
    d_req = 1'b0;
    step();
    check("data_done_one_cycle", {31'b0, d_done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int d_at;
    int i_at;
    int ifc;
    int dc;
    int wr3020;

    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    reset_n = 1'b0;
    if_req  = 1'b0;
    if_addr = 16'h0;
    d_req   = 1'b0;
    d_op    = 2'b00;
    d_addr  = 16'h0;
    d_wdata = 16'h0;

    // Reset values.
    repeat (3) step();
    check("rst_mem_en",   {31'b0, mem_en},  32'h0);
    check("rst_mem_rd",   {31'b0, mem_rd},  32'h1);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    check("rst_mem_din",  {16'b0, mem_din}, 32'h0);
    check("rst_if_data",  {16'b0, if_data}, 32'h0);
    check("rst_d_rdata",  {16'b0, d_rdata}, 32'h0);
    check("rst_if_done",  {31'b0, if_done}, 32'h0);
    check("rst_d_done",   {31'b0, d_done},  32'h0);
    check("rst_err",      {31'b0, err},     32'h0);
    reset_n = 1'b1;
    step();

    // Single fetch, one wait cycle.
    wait_cycles = 1;
    mem[16'h3000] = 16'h1261;
    clear_logs();
    ifc = if_done_cnt;
    run_fetch(16'h3000, lat);
    check("fetch_latency",   lat, 3);
    check("fetch_if_data",   {16'b0, if_data}, 32'h1261);
    check("fetch_n_access",  log_rd.size(), 1);
    check("fetch_rd",        {31'b0, log_rd[0]}, 32'h1);
    check("fetch_addr",      {16'b0, log_addr[0]}, 32'h3000);
    check("fetch_done_cnt",  if_done_cnt - ifc, 1);
    check("fetch_d_rdata",   {16'b0, d_rdata}, 32'h0);

    // Simultaneous requests: data store wins, fetch served afterwards.
    wait_cycles = 0;
    mem[16'h3001] = 16'h2222;
    clear_logs();
    d_op = 2'b01; d_addr = 16'h4000; d_wdata = 16'hBEEF; d_req = 1'b1;
    if_addr = 16'h3001; if_req = 1'b1;
    d_at = 0; i_at = 0;
    for (int i = 1; i <= 100 && !(d_at != 0 && i_at != 0); i++) begin
      step();
      if (d_done === 1'b1 && d_at == 0) begin d_at = i; d_req = 1'b0; end
      if (if_done === 1'b1 && i_at == 0) begin i_at = i; if_req = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
    check("arb_d_done_at",  d_at, 3);
    check("arb_if_done_at", i_at, 7);
    check("arb_n_access",   log_rd.size(), 2);
    if (log_rd.size() == 2) begin
      check("arb_first_wr",   {31'b0, log_rd[0]}, 32'h0);
      check("arb_first_addr", {16'b0, log_addr[0]}, 32'h4000);
      check("arb_first_data", {16'b0, log_data[0]}, 32'hBEEF);
      check("arb_second_rd",  {31'b0, log_rd[1]}, 32'h1);
      check("arb_second_addr",{16'b0, log_addr[1]}, 32'h3001);
    end
    check("arb_mem_4000", {16'b0, mem[16'h4000]}, 32'hBEEF);
    check("arb_if_data",  {16'b0, if_data}, 32'h2222);

    // Plain load; fetch data must be left alone.
    mem[16'h4100] = 16'hCAFE;
    run_data(2'b00, 16'h4100, 16'h0, lat);
    check("ld_latency", lat, 2);
    check("ld_d_rdata", {16'b0, d_rdata}, 32'hCAFE);
    check("ld_if_data_held", {16'b0, if_data}, 32'h2222);

    // LDI: pointer read, one-cycle strobe gap, final read.
    mem[16'h3010] = 16'h5000;
    mem[16'h5000] = 16'h00A5;
    clear_logs();
    dc = d_done_cnt;
    run_data(2'b10, 16'h3010, 16'h0, lat);
    check("ldi_latency", lat, 4);
    check("ldi_d_rdata", {16'b0, d_rdata}, 32'h00A5);
    check("ldi_done_cnt", d_done_cnt - dc, 1);
    check("ldi_n_access", log_rd.size(), 2);
    if (log_rd.size() == 2) begin
      check("ldi_addr0", {16'b0, log_addr[0]}, 32'h3010);
      check("ldi_addr1", {16'b0, log_addr[1]}, 32'h5000);
      check("ldi_rd1",   {31'b0, log_rd[1]}, 32'h1);
    end
    if (rise_q.size() == 2 && fall_q.size() == 2)
      check("ldi_gap", rise_q[1] - fall_q[0], 1);
    else
      check("ldi_strobe_count", rise_q.size(), 2);

    // STI with waits on both accesses.
    wait_cycles = 2;
    mem[16'h3020] = 16'h6000;
    clear_logs();
    run_data(2'b11, 16'h3020, 16'h1234, lat);
    check("sti_latency", lat, 8);
    check("sti_n_access", log_rd.size(), 2);
    if (log_rd.size() == 2) begin
      check("sti_ptr_read", {15'b0, log_rd[0], log_addr[0]}, 32'h13020);
      check("sti_write",    {15'b0, log_rd[1], log_addr[1]}, 32'h06000);
      check("sti_wdata",    {16'b0, log_data[1]}, 32'h1234);
    end
    wr3020 = 0;
    foreach (log_rd[k]) if (!log_rd[k] && log_addr[k] == 16'h3020) wr3020++;
    check("sti_no_ptr_write", wr3020, 0);
    check("sti_mem_6000", {16'b0, mem[16'h6000]}, 32'h1234);
    check("sti_mem_3020", {16'b0, mem[16'h3020]}, 32'h6000);
    wait_cycles = 0;

    // mem_complete with strobe low must do nothing.
    ifc = if_done_cnt;
    dc  = d_done_cnt;
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    step();
    step();
    check("spurious_no_done", (if_done_cnt - ifc) + (d_done_cnt - dc), 0);
    check("spurious_mem_en",  {31'b0, mem_en}, 32'h0);
    check("spurious_d_rdata", {16'b0, d_rdata}, 32'h1234 ^ 32'h1234 ^ 32'h00A5);

    // Reset in the middle of an indirect wait.
    stall = 1'b1;
    d_op = 2'b10; d_addr = 16'h3010; d_wdata = 16'h0; d_req = 1'b1;
    repeat (4) step();
    check("ind_wait_mem_en", {31'b0, mem_en}, 32'h1);
    ifc = if_done_cnt;
    dc  = d_done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_en",  {31'b0, mem_en}, 32'h0);
    check("rst_mid_d_rdata", {16'b0, d_rdata}, 32'h0);
    check("rst_mid_mem_rd",  {31'b0, mem_rd}, 32'h1);
    d_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    stall = 1'b0;
    repeat (3) step();
    check("rst_mid_no_done", (if_done_cnt - ifc) + (d_done_cnt - dc), 0);
    check("rst_mid_idle_en", {31'b0, mem_en}, 32'h0);
    mem[16'h3100] = 16'h7777;
    run_fetch(16'h3100, lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_if_data", {16'b0, if_data}, 32'h7777);

`ifdef LC3_MEM_TIMEOUT_EN
    // Timeout: memory never answers.
    stall = 1'b1;
    clear_logs();
    run_fetch(16'h3200, lat);
    stall = 1'b0;
    check("tmo_latency", lat, TMO + 1);
    if (rise_q.size() == 1 && fall_q.size() == 1)
      check("tmo_strobe_len", fall_q[0] - rise_q[0], TMO);
    else
      check("tmo_strobe_count", rise_q.size(), 1);
    check("tmo_err", {31'b0, err}, 32'h1);
    check("tmo_if_data_held", {16'b0, if_data}, 32'h7777);
    mem[16'h3300] = 16'h0B0B;
    run_fetch(16'h3300, lat);
    check("tmo_next_latency", lat, 2);
    check("tmo_err_sticky", {31'b0, err}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("tmo_err_reset", {31'b0, err}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
`else
    check("err_tied_low", {31'b0, err}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
